control_unit_mc: RTL and testbench

//  Multi-cycle controller for the RV32I integer core. Accepts one instruction over a valid/ready

---
 rtl/control_unit_mc_if.sv | 27 ++
 rtl/control_unit_mc.sv | 235 +++++++++++++++++++++++
 tb/tb_control_unit_mc.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_mc_if.sv
// ---------------------------------------------------------------------------
// control_unit_mc_if
//   Instruction handshake between fetch (master) and the multi-cycle
//   controller (slave).
//   instr        : instruction word, sampled on the accept edge
//   instr_valid  : fetch presents instr
//   instr_ready  : controller can take an instruction this cycle
// ---------------------------------------------------------------------------
interface control_unit_mc_if #(
    parameter int INSTR_WIDTH = 32
);
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/control_unit_mc.sv
// ---------------------------------------------------------------------------
// control_unit_mc
//   Multi-cycle RV32I ALU-op controller. Accepts one instruction over the
//   bus handshake and sequences DECODE -> EXECUTE (EX_CYCLES) -> WRITEBACK.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     bus (slave)   : instr / instr_valid in, instr_ready out
//     rd_addr       : destination register (instr[11:7])
//     data_imm_sel  : 0 = ALU B from rs2, 1 = from immediate
//     alu_op        : 0 NOP,1 ADD,2 SUB,3 OR,4 AND,5 XOR,6 SLL,7 SRL,
//                     8 SRA,9 SLT,10 SLTU (upper bits zero)
//     alu_en        : high in every EXECUTE cycle
//     reg_wen       : high in the WRITEBACK cycle
//     done          : pulse in WRITEBACK, or in DECODE for an illegal op
//     illegal       : pulse in DECODE for an unsupported encoding
//   All outputs are registered. Each output flop is loaded with the value
//   the next state requires, so it is valid for the whole cycle the FSM
//   spends in that state.
// ---------------------------------------------------------------------------
module control_unit_mc #(
    parameter int INSTR_WIDTH  = 32,
    parameter int ALU_OP_WIDTH = 4,
    parameter int EX_CYCLES    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    control_unit_mc_if.slave        bus,
    output logic [4:0]              rd_addr,
    output logic                    data_imm_sel,
    output logic [ALU_OP_WIDTH-1:0] alu_op,
    output logic                    alu_en,
    output logic                    reg_wen,
    output logic                    done,
    output logic                    illegal
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DECODE,
        S_EXECUTE,
        S_WRITEBACK
    } state_t;

    localparam logic [6:0] OPC_R = 7'b0110011;
    localparam logic [6:0] OPC_I = 7'b0010011;
    localparam logic [6:0] F7_Z  = 7'b0000000;
    localparam logic [6:0] F7_A  = 7'b0100000;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_AND  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SLL  = 4'd6;
    localparam logic [3:0] OP_SRL  = 4'd7;
    localparam logic [3:0] OP_SRA  = 4'd8;
    localparam logic [3:0] OP_SLT  = 4'd9;
    localparam logic [3:0] OP_SLTU = 4'd10;

    localparam logic [3:0] EX_LAST = 4'(EX_CYCLES - 1);

    // Instruction fields
    logic [INSTR_WIDTH-1:0] instr_w;
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic                   unused_lo;

    assign instr_w   = bus.instr;
    assign opcode    = instr_w[6:0];
    assign funct3    = instr_w[14:12];
    assign funct7    = instr_w[31:25];
    // rs1/rs2/imm bits are routed to the datapath elsewhere.
    assign unused_lo = ^instr_w[24:15];

    genvar gi;
    generate
        for (gi = 32; gi < INSTR_WIDTH; gi++) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = instr_w[gi];
        end
    endgenerate

    // Combinational decode of the word on the bus; it is captured on the
    // accept edge so the decoded fields are already valid during DECODE.
    logic       dec_legal;
    logic [3:0] dec_op;

    always_comb begin
        dec_legal = 1'b0;
        dec_op    = OP_NOP;
        if (opcode == OPC_R) begin
            unique case ({funct7, funct3})
                {F7_Z, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_ADD;  end
                {F7_Z, 3'b001}: begin dec_legal = 1'b1; dec_op = OP_SLL;  end
                {F7_Z, 3'b010}: begin dec_legal = 1'b1; dec_op = OP_SLT;  end
                {F7_Z, 3'b011}: begin dec_legal = 1'b1; dec_op = OP_SLTU; end
                {F7_Z, 3'b100}: begin dec_legal = 1'b1; dec_op = OP_XOR;  end
                {F7_Z, 3'b101}: begin dec_legal = 1'b1; dec_op = OP_SRL;  end
                {F7_Z, 3'b110}: begin dec_legal = 1'b1; dec_op = OP_OR;   end
                {F7_Z, 3'b111}: begin dec_legal = 1'b1; dec_op = OP_AND;  end
                {F7_A, 3'b000}: begin dec_legal = 1'b1; dec_op = OP_SUB;  end
                {F7_A, 3'b101}: begin dec_legal = 1'b1; dec_op = OP_SRA;  end
                default:        begin dec_legal = 1'b0; dec_op = OP_NOP;  end
            endcase
        end else if (opcode == OPC_I) begin
            unique case (funct3)
                3'b000: begin dec_legal = 1'b1; dec_op = OP_ADD;  end
                3'b010: begin dec_legal = 1'b1; dec_op = OP_SLT;  end
                3'b011: begin dec_legal = 1'b1; dec_op = OP_SLTU; end
                3'b100: begin dec_legal = 1'b1; dec_op = OP_XOR;  end
                3'b110: begin dec_legal = 1'b1; dec_op = OP_OR;   end
                3'b111: begin dec_legal = 1'b1; dec_op = OP_AND;  end
                // Shifts use funct7 as part of the opcode.
                3'b001: begin
                    dec_legal = (funct7 == F7_Z);
                    dec_op    = dec_legal ? OP_SLL : OP_NOP;
                end
                default: begin
                    if (funct7 == F7_Z) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SRL;
                    end else if (funct7 == F7_A) begin
                        dec_legal = 1'b1;
                        dec_op    = OP_SRA;
                    end else begin
                        dec_legal = 1'b0;
                        dec_op    = OP_NOP;
                    end
                end
            endcase
        end
    end

    // State and registered outputs
    state_t     state_q, state_d;
    logic [3:0] ex_cnt_q, ex_cnt_d;
    logic [4:0] rd_addr_q, rd_addr_d;
    logic       imm_sel_q, imm_sel_d;
    logic [3:0] alu_op_q, alu_op_d;
    logic       instr_ready_q, instr_ready_d;
    logic       alu_en_q, alu_en_d;
    logic       reg_wen_q, reg_wen_d;
    logic       done_q, done_d;
    logic       illegal_q, illegal_d;

    always_comb begin
        state_d       = state_q;
        ex_cnt_d      = ex_cnt_q;
        rd_addr_d     = rd_addr_q;
        imm_sel_d     = imm_sel_q;
        alu_op_d      = alu_op_q;
        instr_ready_d = instr_ready_q;
        alu_en_d      = 1'b0;
        reg_wen_d     = 1'b0;
        done_d        = 1'b0;
        illegal_d     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.instr_valid && instr_ready_q) begin
                    state_d       = S_DECODE;
                    rd_addr_d     = instr_w[11:7];
                    imm_sel_d     = (opcode == OPC_I);
                    alu_op_d      = dec_op;
                    illegal_d     = !dec_legal;
                    done_d        = !dec_legal;
                    instr_ready_d = 1'b0;
                end
            end
            S_DECODE: begin
                // illegal_q doubles as the legality record of this instr.
                if (illegal_q) begin
                    state_d       = S_IDLE;
                    instr_ready_d = 1'b1;
                end else begin
                    state_d  = S_EXECUTE;
                    ex_cnt_d = 4'd0;
                    alu_en_d = 1'b1;
                end
            end
            S_EXECUTE: begin
                if (ex_cnt_q == EX_LAST) begin
                    state_d   = S_WRITEBACK;
                    reg_wen_d = 1'b1;
                    done_d    = 1'b1;
                end else begin
                    ex_cnt_d = ex_cnt_q + 4'd1;
                    alu_en_d = 1'b1;
                end
            end
            default: begin
                state_d       = S_IDLE;
                instr_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ex_cnt_q      <= 4'd0;
            rd_addr_q     <= 5'd0;
            imm_sel_q     <= 1'b0;
            alu_op_q      <= OP_NOP;
            instr_ready_q <= 1'b1;
            alu_en_q      <= 1'b0;
            reg_wen_q     <= 1'b0;
            done_q        <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ex_cnt_q      <= ex_cnt_d;
            rd_addr_q     <= rd_addr_d;
            imm_sel_q     <= imm_sel_d;
            alu_op_q      <= alu_op_d;
            instr_ready_q <= instr_ready_d;
            alu_en_q      <= alu_en_d;
            reg_wen_q     <= reg_wen_d;
            done_q        <= done_d;
            illegal_q     <= illegal_d;
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign rd_addr         = rd_addr_q;
    assign data_imm_sel    = imm_sel_q;
    assign alu_op          = ALU_OP_WIDTH'(alu_op_q);
    assign alu_en          = alu_en_q;
    assign reg_wen         = reg_wen_q;
    assign done            = done_q;
    assign illegal         = illegal_q;

endmodule

// File: tb/tb_control_unit_mc.sv
// ---------------------------------------------------------------------------
// tb_control_unit_mc
//   Two controllers (EX_CYCLES=1 and 4) share one stimulus stream. A
//   per-instruction position model predicts every output each cycle;
//   directed transactions pin the model with literal expectations, then a
//   random stream (including held valid, changing words and random resets)
//   runs against the model.
// ---------------------------------------------------------------------------
module tb_control_unit_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr_drv = 32'd0;
    logic        valid_drv = 1'b0;

    always #5 clk = ~clk;

    control_unit_mc_if #(.INSTR_WIDTH(32)) bus1 ();
    control_unit_mc_if #(.INSTR_WIDTH(32)) bus4 ();

    assign bus1.instr       = instr_drv;
    assign bus1.instr_valid = valid_drv;
    assign bus4.instr       = instr_drv;
    assign bus4.instr_valid = valid_drv;

    logic [4:0] a_rd   [2];
    logic       a_imm  [2];
    logic [3:0] a_op   [2];
    logic       a_aen  [2];
    logic       a_rw   [2];
    logic       a_dn   [2];
    logic       a_ill  [2];
    logic       a_rdy  [2];

    assign a_rdy[0] = bus1.instr_ready;
    assign a_rdy[1] = bus4.instr_ready;

    control_unit_mc #(.INSTR_WIDTH(32), .ALU_OP_WIDTH(4), .EX_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1),
        .rd_addr(a_rd[0]), .data_imm_sel(a_imm[0]), .alu_op(a_op[0]),
        .alu_en(a_aen[0]), .reg_wen(a_rw[0]), .done(a_dn[0]), .illegal(a_ill[0])
    );

    control_unit_mc #(.INSTR_WIDTH(32), .ALU_OP_WIDTH(4), .EX_CYCLES(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4),
        .rd_addr(a_rd[1]), .data_imm_sel(a_imm[1]), .alu_op(a_op[1]),
        .alu_en(a_aen[1]), .reg_wen(a_rw[1]), .done(a_dn[1]), .illegal(a_ill[1])
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference decode tables indexed by funct3.
    int r_tab [8] = '{1, 6, 9, 10, 5, 7, 3, 4};
    int i_tab [8] = '{1, 6, 9, 10, 5, 7, 3, 4};
    int ex_tab[2] = '{1, 4};

    task automatic ref_decode(input logic [31:0] w, output bit legal, output logic [3:0] op);
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        opc   = w[6:0];
        f3    = w[14:12];
        f7    = w[31:25];
        legal = 1'b0;
        op    = 4'd0;
        if (opc == 7'h33) begin
            if (f7 == 7'h00) begin
                legal = 1'b1; op = 4'(r_tab[f3]);
            end else if (f7 == 7'h20 && f3 == 3'd0) begin
                legal = 1'b1; op = 4'd2;
            end else if (f7 == 7'h20 && f3 == 3'd5) begin
                legal = 1'b1; op = 4'd8;
            end
        end else if (opc == 7'h13) begin
            if (f3 == 3'd1) begin
                legal = (f7 == 7'h00); op = 4'd6;
            end else if (f3 == 3'd5) begin
                if (f7 == 7'h00) begin legal = 1'b1; op = 4'd7; end
                else if (f7 == 7'h20) begin legal = 1'b1; op = 4'd8; end
            end else begin
                legal = 1'b1; op = 4'(i_tab[f3]);
            end
        end
        if (!legal) op = 4'd0;
    endtask

    // Model: p = position within the current instruction
    // (0 idle, 1 decode, 2..1+EX execute, 2+EX writeback).
    int         p      [2];
    bit         m_legal[2];
    logic [4:0] m_rd   [2];
    logic       m_imm  [2];
    logic [3:0] m_op   [2];
    bit         model_on = 1'b0;

    always @(posedge clk) begin
        bit         lg;
        logic [3:0] o;
        if (rst) model_on = 1'b1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                p[d] = 0; m_legal[d] = 1'b1; m_rd[d] = 5'd0; m_imm[d] = 1'b0; m_op[d] = 4'd0;
            end else if (p[d] == 0) begin
                if (valid_drv) begin
                    ref_decode(instr_drv, lg, o);
                    p[d]       = 1;
                    m_legal[d] = lg;
                    m_op[d]    = o;
                    m_rd[d]    = instr_drv[11:7];
                    m_imm[d]   = (instr_drv[6:0] == 7'h13);
                end
            end else if (!m_legal[d] && p[d] == 1) begin
                p[d] = 0;
            end else if (p[d] == 2 + ex_tab[d]) begin
                p[d] = 0;
            end else begin
                p[d] = p[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            for (int d = 0; d < 2; d++) begin
                int ex;
                int pp;
                string tag;
                ex  = ex_tab[d];
                pp  = p[d];
                tag = $sformatf("ex%0d", ex);
                chk({tag, "_ready"},   int'(a_rdy[d]), int'(pp == 0));
                chk({tag, "_rd"},      int'(a_rd[d]),  int'(m_rd[d]));
                chk({tag, "_imm"},     int'(a_imm[d]), int'(m_imm[d]));
                chk({tag, "_aluop"},   int'(a_op[d]),  int'(m_op[d]));
                chk({tag, "_alu_en"},  int'(a_aen[d]), int'(m_legal[d] && pp >= 2 && pp <= 1 + ex));
                chk({tag, "_reg_wen"}, int'(a_rw[d]),  int'(m_legal[d] && pp == 2 + ex));
                chk({tag, "_done"},    int'(a_dn[d]),  int'(m_legal[d] ? (pp == 2 + ex) : (pp == 1)));
                chk({tag, "_illegal"}, int'(a_ill[d]), int'(!m_legal[d] && pp == 1));
            end
        end
    end

    // Send one instruction with a one-cycle valid and record per-cycle
    // output bits; bit k is the k-th cycle after the accept edge.
    logic [11:0] rw1v, dn1v, ill1v, rdy1v, aen4v, rw4v;

    task automatic run_one(input logic [31:0] w);
        @(posedge clk); #2;
        instr_drv = w;
        valid_drv = 1'b1;
        @(posedge clk); #2;
        valid_drv = 1'b0;
        rw1v = '0; dn1v = '0; ill1v = '0; rdy1v = '0; aen4v = '0; rw4v = '0;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            rw1v[k]  = a_rw[0];
            dn1v[k]  = a_dn[0];
            ill1v[k] = a_ill[0];
            rdy1v[k] = a_rdy[0];
            aen4v[k] = a_aen[1];
            rw4v[k]  = a_rw[1];
        end
        $display("txn instr=%08h rw1=%03h dn1=%03h ill1=%03h aen4=%03h rw4=%03h",
                 w, rw1v, dn1v, ill1v, aen4v, rw4v);
    endtask

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int sel;
        w   = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 4)      w[6:0] = 7'h33;
        else if (sel < 8) w[6:0] = 7'h13;
        sel = $urandom_range(0, 3);
        if (sel < 2)       w[31:25] = 7'h00;
        else if (sel == 2) w[31:25] = 7'h20;
        return w;
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_ready",   int'(a_rdy[1]), 1);
        chk("rst_reg_wen", int'(a_rw[1]),  0);
        chk("rst_alu_op",  int'(a_op[1]),  0);
        chk("rst_rd",      int'(a_rd[1]),  0);

        // ADD x3,x1,x2
        run_one(32'h002081B3);
        chk("add_op",      int'(a_op[0]),  1);
        chk("add_imm",     int'(a_imm[0]), 0);
        chk("add_rd",      int'(a_rd[0]),  3);
        chk("add_rw1_pos", int'(rw1v),     int'(12'h008));
        chk("add_dn1_pos", int'(dn1v),     int'(12'h008));
        chk("add_rw4_pos", int'(rw4v),     int'(12'h040));

        // SUB then SRAI
        run_one(32'h402081B3);
        chk("sub_op", int'(a_op[0]), 2);
        run_one(32'h4030D293);
        chk("srai_op",  int'(a_op[0]),  8);
        chk("srai_imm", int'(a_imm[0]), 1);
        chk("srai_rd",  int'(a_rd[0]),  5);

        // ADDI x1,x0,5 on the EX_CYCLES=4 unit
        run_one(32'h00500093);
        chk("addi_aen4", int'(aen4v),    int'(12'h03C));
        chk("addi_rw4",  int'(rw4v),     int'(12'h040));
        chk("addi_op",   int'(a_op[1]),  1);

        // Illegal opcode, then R-type with funct7=0000001
        run_one(32'h0000007F);
        chk("ill_pulse", int'(ill1v),      int'(12'h002));
        chk("ill_done",  int'(dn1v),       int'(12'h002));
        chk("ill_rw",    int'(rw1v),       0);
        chk("ill_ready", int'(rdy1v[2:1]), 2);
        chk("ill_op",    int'(a_op[0]),    0);
        run_one(32'h022081B3);
        chk("ill2_pulse", int'(ill1v), int'(12'h002));
        chk("ill2_rw",    int'(rw1v),  0);

        // Reset during EXECUTE of ADD
        @(posedge clk); #2;
        instr_drv = 32'h002081B3;
        valid_drv = 1'b1;
        @(posedge clk); #2;
        valid_drv = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #2 rst = 1'b1;
        @(posedge clk); #2 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready", int'(a_rdy[1]), 1);
        chk("mid_rst_aen",   int'(a_aen[1]), 0);
        chk("mid_rst_op",    int'(a_op[1]),  0);
        chk("mid_rst_rd",    int'(a_rd[1]),  0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("mid_rst_no_wen1", int'(a_rw[0]), 0);
            chk("mid_rst_no_wen4", int'(a_rw[1]), 0);
        end
        $display("txn reset-during-execute complete");

        // Random stream: valid often held high with changing words
        for (int n = 0; n < 3000; n++) begin
            @(posedge clk); #2;
            valid_drv = ($urandom_range(0, 3) != 0);
            instr_drv = gen_instr();
            rst       = ($urandom_range(0, 249) == 0);
        end
        @(posedge clk); #2;
        rst       = 1'b0;
        valid_drv = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
